// File: rtl/lsu_gpio_mem.sv
// Load/store unit for the KRV-32 core: byte-addressable data RAM plus GPIO
// registers behind a valid/ready request and a one-cycle response strobe.
module lsu_gpio_mem #(
  parameter logic [31:0] DATA_BASE = 32'd1000,
  parameter int          MEM_WORDS = 16,
  parameter logic [31:0] GPIO_BASE = 32'd2048,
  parameter int          GPIO_N    = 6,
  parameter bit          GPIO_INV  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [GPIO_N-1:0] gpio_out,
  input  logic [GPIO_N-1:0] gpio_in
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [31:0] GPI_ADDR  = GPIO_BASE + 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [2:0] funct3);
    logic [31:0] res;
    case (funct3)
      3'b000:  res = {{24{word[7]}}, word[7:0]};
      3'b001:  res = {{16{word[15]}}, word[15:0]};
      3'b100:  res = {24'd0, word[7:0]};
      3'b101:  res = {16'd0, word[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [GPIO_N-1:0]   r_gpo;
  logic [GPIO_N-1:0]   r_gpi_meta;
  logic [GPIO_N-1:0]   r_gpi_sync;
  logic [31:0]         r_mem [MEM_WORDS];

  logic [31:0]         w_off;
  logic [IDX_W-1:0]    w_idx;
  logic [1:0]          w_lane;
  logic                w_ram_hit;
  logic                w_gpo_hit;
  logic                w_gpi_hit;
  logic                w_f3_ok;
  logic                w_align_ok;
  logic                w_err;
  logic [31:0]         w_rd_word;
  logic [31:0]         w_load;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata_sh;
  logic [31:0]         w_gpo_merge;
  logic                w_ram_we;
  logic                w_gpo_we;

  // Offset arithmetic wraps, so addresses below DATA_BASE fall out of range.
  assign w_off      = r_addr - DATA_BASE;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_lane     = w_off[1:0];
  assign w_ram_hit  = (w_off < RAM_BYTES);
  assign w_gpo_hit  = (r_addr == GPIO_BASE);
  assign w_gpi_hit  = (r_addr == GPI_ADDR);
  assign w_be       = f_byte_en(r_funct3, w_lane);
  assign w_wdata_sh = r_wdata << {w_lane, 3'b000};
  assign w_load     = f_extend(w_rd_word >> {w_lane, 3'b000}, r_funct3);

  // Legality checks on the latched request.
  always_comb begin
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b0;
    case (r_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !r_we;
      default:                w_f3_ok = 1'b0;
    endcase
    case (r_funct3[1:0])
      2'b00:   w_align_ok = 1'b1;
      2'b01:   w_align_ok = !r_addr[0];
      2'b10:   w_align_ok = (r_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
    w_err = !w_f3_ok || !w_align_ok || !(w_ram_hit || w_gpo_hit || w_gpi_hit)
            || (r_we && w_gpi_hit);
  end

  // Source word for loads, selected by the decoded region.
  always_comb begin
    w_rd_word = 32'd0;
    if (w_ram_hit) begin
      w_rd_word = r_mem[w_idx];
    end else if (w_gpo_hit) begin
      w_rd_word = 32'(r_gpo);
    end else if (w_gpi_hit) begin
      w_rd_word = 32'(r_gpi_sync);
    end else begin
      w_rd_word = 32'd0;
    end
  end

  // Byte-lane merge of store data into the current GPIO output value.
  always_comb begin
    w_gpo_merge = 32'(r_gpo);
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) begin
        w_gpo_merge[8*b +: 8] = w_wdata_sh[8*b +: 8];
      end else begin
        w_gpo_merge[8*b +: 8] = w_gpo_merge[8*b +: 8];
      end
    end
  end

  assign w_ram_we = (r_state == ACCESS) && r_we && w_ram_hit && !w_err;
  assign w_gpo_we = (r_state == ACCESS) && r_we && w_gpo_hit && !w_err;

  // Next-state logic: one accepted request walks IDLE -> ACCESS -> RESP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, handshake, request latch, response and GPIO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_gpo       <= '0;
      r_gpi_meta  <= '0;
      r_gpi_sync  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      r_gpi_meta  <= gpio_in;
      r_gpi_sync  <= r_gpi_meta;
      if (r_state == IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == ACCESS) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
      end
      if (w_gpo_we) begin
        r_gpo <= w_gpo_merge[GPIO_N-1:0];
      end
    end
  end

  // Byte-enabled RAM write at the end of ACCESS; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign gpio_out  = r_gpo ^ {GPIO_N{GPIO_INV}};

endmodule

// File: tb/tb_lsu_gpio_mem.sv
// Self-checking bench for lsu_gpio_mem: directed vector table, handshake and
// reset-abort sequences, then random traffic against a byte-level model.
module tb_lsu_gpio_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  gpio_out;
  logic [5:0]  gpio_in;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  model_ram [64];
  logic [31:0] model_gpo;
  logic [5:0]  model_gpi;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [5:0]  exp_gpio;
  } vec_t;

  vec_t tbl [20];

  lsu_gpio_mem dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference: RV32I load/store semantics on a byte array and GPIO values.
  function automatic void model_access(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic err);
    int size;
    bit legal;
    bit sgn;
    int region;
    logic [31:0] v;
    logic [31:0] src;
    size = 1; legal = 1'b1; sgn = 1'b0;
    case (f3)
      3'd0:    begin size = 1; sgn = 1'b1; end
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    size = 4;
      3'd4:    begin size = 1; legal = !we; end
      3'd5:    begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    if (addr >= 32'd1000 && addr < 32'd1064) region = 1;
    else if (addr == 32'd2048) region = 2;
    else if (addr == 32'd2052) region = 3;
    else region = 0;
    err = !legal || (addr % size != 0) || region == 0 || (we && region == 3);
    rd = 32'd0;
    if (err) return;
    if (we) begin
      if (region == 1) begin
        for (int i = 0; i < size; i++) model_ram[int'(addr - 32'd1000) + i] = wdata[8*i +: 8];
      end else begin
        v = model_gpo;
        for (int i = 0; i < size; i++) v[8*i +: 8] = wdata[8*i +: 8];
        model_gpo = v & 32'h3F;
      end
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) begin
        if (region == 1) v[8*i +: 8] = model_ram[int'(addr - 32'd1000) + i];
        else begin
          src = (region == 2) ? model_gpo : 32'(model_gpi);
          v[8*i +: 8] = src[8*i +: 8];
        end
      end
      if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
    end
  endfunction

  // Issue one request from a falling edge and collect its response (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 6) begin @(negedge clk); n++; end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        we;
    int accepts, low_cnt, pulses, rsp_at;

    tbl[0]  = '{1'b1, 3'b010, 32'd1000, 32'h11223344, 32'h0,        1'b0, 6'h3F};
    tbl[1]  = '{1'b0, 3'b010, 32'd1000, 32'h0,        32'h11223344, 1'b0, 6'h3F};
    tbl[2]  = '{1'b0, 3'b000, 32'd1001, 32'h0,        32'h00000033, 1'b0, 6'h3F};
    tbl[3]  = '{1'b0, 3'b101, 32'd1002, 32'h0,        32'h00001122, 1'b0, 6'h3F};
    tbl[4]  = '{1'b1, 3'b000, 32'd1002, 32'h00000080, 32'h0,        1'b0, 6'h3F};
    tbl[5]  = '{1'b0, 3'b000, 32'd1002, 32'h0,        32'hFFFFFF80, 1'b0, 6'h3F};
    tbl[6]  = '{1'b0, 3'b100, 32'd1002, 32'h0,        32'h00000080, 1'b0, 6'h3F};
    tbl[7]  = '{1'b0, 3'b010, 32'd1000, 32'h0,        32'h11803344, 1'b0, 6'h3F};
    tbl[8]  = '{1'b0, 3'b010, 32'd1002, 32'h0,        32'h0,        1'b1, 6'h3F};
    tbl[9]  = '{1'b1, 3'b001, 32'd1001, 32'h0000FFFF, 32'h0,        1'b1, 6'h3F};
    tbl[10] = '{1'b0, 3'b010, 32'd1000, 32'h0,        32'h11803344, 1'b0, 6'h3F};
    tbl[11] = '{1'b0, 3'b000, 32'd999,  32'h0,        32'h0,        1'b1, 6'h3F};
    tbl[12] = '{1'b0, 3'b000, 32'd1064, 32'h0,        32'h0,        1'b1, 6'h3F};
    tbl[13] = '{1'b0, 3'b011, 32'd1000, 32'h0,        32'h0,        1'b1, 6'h3F};
    tbl[14] = '{1'b1, 3'b010, 32'd2048, 32'h00000015, 32'h0,        1'b0, 6'h2A};
    tbl[15] = '{1'b0, 3'b010, 32'd2048, 32'h0,        32'h00000015, 1'b0, 6'h2A};
    tbl[16] = '{1'b0, 3'b010, 32'd2052, 32'h0,        32'h00000009, 1'b0, 6'h2A};
    tbl[17] = '{1'b1, 3'b010, 32'd2052, 32'h00000001, 32'h0,        1'b1, 6'h2A};
    tbl[18] = '{1'b1, 3'b100, 32'd1000, 32'hFFFFFFFF, 32'h0,        1'b1, 6'h2A};
    tbl[19] = '{1'b0, 3'b010, 32'd1000, 32'h0,        32'h11803344, 1'b0, 6'h2A};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; gpio_in = 6'h09;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_gpio_out", 32'(gpio_out), 32'h3F);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, err);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_gpio", i), 32'(gpio_out), 32'(tbl[i].exp_gpio));
    end

    // Request presented through the busy period, dropped once answered.
    while (!req_ready) @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd1000; req_valid = 1'b1;
    accepts = 0; low_cnt = 0; pulses = 0; rsp_at = -1;
    for (int k = 0; k < 7; k++) begin
      if (req_valid && req_ready) accepts++;
      if (!req_ready) low_cnt++;
      if (rsp_valid) begin
        pulses++;
        rsp_at = k;
        chk("hold_rdata", rsp_rdata, 32'h11803344);
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hold_accepts", 32'(accepts), 32'd1);
    chk("hold_ready_low", 32'(low_cnt), 32'd2);
    chk("hold_rsp_pulses", 32'(pulses), 32'd1);
    chk("hold_rsp_cycle", 32'(rsp_at), 32'd2);

    // Reset during ACCESS of a store aborts it without writing.
    do_req(1'b1, 3'b010, 32'd1004, 32'hCAFEF00D, rd, err);
    chk("pre_abort_sw_err", 32'(err), 32'd0);
    do_req(1'b0, 3'b010, 32'd1004, 32'h0, rd, err);
    chk("pre_abort_lw", rd, 32'hCAFEF00D);
    while (!req_ready) @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd1004; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_gpio_out", 32'(gpio_out), 32'h3F);
    chk("abort_rdata", rsp_rdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    chk("abort_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_rsp_after", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'b010, 32'd1004, 32'h0, rd, err);
    chk("abort_no_write", rd, 32'hCAFEF00D);

    // Random traffic against the model after a full RAM preload.
    model_gpo = 32'd0;
    model_gpi = gpio_in;
    for (int w = 0; w < 16; w++) begin
      addr = 32'd1000 + 32'(4 * w);
      model_access(1'b1, 3'b010, addr, $urandom, exp_rd, exp_err);
      do_req(1'b1, 3'b010, addr, {model_ram[4*w+3], model_ram[4*w+2],
                                  model_ram[4*w+1], model_ram[4*w]}, rd, err);
      chk("preload_err", 32'(err), 32'(exp_err));
    end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        gpio_in = 6'($urandom);
        model_gpi = gpio_in;
        repeat (3) @(negedge clk);
      end
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      if ($urandom_range(0, 9) < 7) addr = 32'd996 + 32'($urandom_range(0, 72));
      else begin
        case ($urandom_range(0, 5))
          0, 1: addr = 32'd2048;
          2, 3: addr = 32'd2052;
          4: addr = 32'd2050;
          default: addr = 32'd2056;
        endcase
      end
      req_wdata = $urandom;
      model_access(we, f3, addr, req_wdata, exp_rd, exp_err);
      do_req(we, f3, addr, req_wdata, rd, err);
      chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rand%0d_err", i), 32'(err), 32'(exp_err));
      chk($sformatf("rand%0d_gpio", i), 32'(gpio_out), ~model_gpo & 32'h3F);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
